// File: rtl/retire_trace_fifo_if.sv
// Read-side handshake of the retirement trace buffer: show-ahead valid/ready with
// the head entry's {pc, result}. The buffer is master, the consumer is slave.
interface retire_trace_fifo_if #(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] result;

  modport master (
    output valid,
    output pc,
    output result,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  result,
    output ready
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// Retirement tracer: captures {pc, result} whenever the observed PC changes and
// queues it in a circular buffer drained through a show-ahead valid/ready port.
module retire_trace_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trace_en_i,
  input  logic [PC_W-1:0]     pc_i,
  input  logic [DATA_W-1:0]   result_i,
  input  logic                clear_ovf_i,
  retire_trace_fifo_if.master out_if,
  output logic [CntW-1:0]     count_o,
  output logic                overflow_o,
  output logic [7:0]          drop_count_o
);

  logic [PC_W-1:0]   pc_mem_q  [DEPTH];
  logic [DATA_W-1:0] res_mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            armed_q, armed_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;

  logic push_req, full, not_empty, pop, do_push, drop;

  always_comb begin
    push_req  = trace_en_i && (!armed_q || (pc_i != prev_pc_q));
    full      = (count_q == CntW'(DEPTH));
    not_empty = (count_q != '0);
    pop       = not_empty && out_if.ready;
    // A pop on the same edge frees a slot, so a full buffer still accepts.
    do_push   = push_req && (!full || pop);
    drop      = push_req && full && !pop;

    wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    armed_d   = trace_en_i;
    prev_pc_d = trace_en_i ? pc_i : prev_pc_q;

    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_ovf_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      armed_q    <= 1'b0;
      prev_pc_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      armed_q    <= armed_d;
      prev_pc_q  <= prev_pc_d;
    end
  end

  // Storage needs no reset: it is only observable through the gated head read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pc_mem_q[wr_ptr_q]  <= pc_i;
      res_mem_q[wr_ptr_q] <= result_i;
    end
  end

  always_comb begin
    out_if.valid  = not_empty;
    out_if.pc     = not_empty ? pc_mem_q[rd_ptr_q] : '0;
    out_if.result = not_empty ? res_mem_q[rd_ptr_q] : '0;
  end

  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Bench for retire_trace_fifo: directed scenarios plus randomized traffic checked
// against a queue-based model of the trace buffer.
module tb_retire_trace_fifo;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] res;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              trace_en;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] result;
  logic              clear_ovf;
  logic [4:0]        count;
  logic              overflow;
  logic [7:0]        drop_count;

  retire_trace_fifo_if #(.PC_W(PC_W), .DATA_W(DATA_W)) out_if ();

  retire_trace_fifo #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trace_en_i   (trace_en),
    .pc_i         (pc),
    .result_i     (result),
    .clear_ovf_i  (clear_ovf),
    .out_if       (out_if),
    .count_o      (count),
    .overflow_o   (overflow),
    .drop_count_o (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  ent_t            mq[$];
  bit              m_armed;
  logic [PC_W-1:0] m_prev;
  bit              m_ovf;
  int              m_drops;

  task automatic model_reset();
    mq.delete();
    m_armed = 0;
    m_prev  = '0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic model_step();
    bit   do_pop, want;
    ent_t e;
    do_pop = (mq.size() != 0) && out_if.ready;
    want   = trace_en && (!m_armed || pc != m_prev);
    if (trace_en) begin
      m_prev  = pc;
      m_armed = 1;
    end else begin
      m_armed = 0;
    end
    if (do_pop) void'(mq.pop_front());
    if (want) begin
      e.pc  = pc;
      e.res = result;
      if (mq.size() < DEPTH) mq.push_back(e);
      else if (!clear_ovf) begin
        m_ovf = 1;
        if (m_drops != 255) m_drops++;
      end
    end
    if (clear_ovf) begin
      m_ovf   = 0;
      m_drops = 0;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; trace_en = 1; clear_ovf = 0; out_if.ready = 0; result = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      pc = 8'(i);
      clk_step();
    end
    n_checks++; if (out_if.valid !== 1'b0) $display("FAIL reset_valid got %0h want 0", out_if.valid); else n_pass++;
    n_checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %0h want 0", overflow); else n_pass++;
    n_checks++; if (drop_count !== 8'd0) $display("FAIL reset_drops got %0d want 0", drop_count); else n_pass++;
    n_checks++; if (out_if.pc !== 8'd0) $display("FAIL reset_pc got %0h want 0", out_if.pc); else n_pass++;
    trace_en = 0;
    rst_n = 1;
    clk_step();
  endtask

  task automatic test_retire_detect();
    logic [PC_W-1:0]   pcs  [5] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2};
    logic [DATA_W-1:0] ress [5] = '{32'd5, 32'd5, 32'd7, 32'd7, 32'd9};
    logic [PC_W-1:0]   exp_pc  [3] = '{8'd0, 8'd1, 8'd2};
    logic [DATA_W-1:0] exp_res [3] = '{32'd5, 32'd7, 32'd9};
    out_if.ready = 0; trace_en = 1;
    for (int i = 0; i < 5; i++) begin
      pc = pcs[i]; result = ress[i];
      clk_step();
    end
    trace_en = 0;
    n_checks++; if (count !== 5'd3) $display("FAIL detect_count got %0d want 3", count); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_if.valid !== 1'b1 || out_if.pc !== exp_pc[k] || out_if.result !== exp_res[k])
        $display("FAIL detect_pop%0d got v=%0h pc=%0h res=%0h want v=1 pc=%0h res=%0h", k,
                 out_if.valid, out_if.pc, out_if.result, exp_pc[k], exp_res[k]);
      else n_pass++;
      out_if.ready = 1;
      clk_step();
      out_if.ready = 0;
    end
    n_checks++; if (count !== 5'd0) $display("FAIL detect_empty got %0d want 0", count); else n_pass++;
  endtask

  task automatic test_full_drop();
    out_if.ready = 0; trace_en = 1;
    for (int i = 0; i < 18; i++) begin
      pc = 8'(i); result = 32'(i * 3 + 1);
      clk_step();
    end
    trace_en = 0;
    n_checks++; if (count !== 5'd16) $display("FAIL full_count got %0d want 16", count); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL full_ovf got %0h want 1", overflow); else n_pass++;
    n_checks++; if (drop_count !== 8'd2) $display("FAIL full_drops got %0d want 2", drop_count); else n_pass++;
    out_if.ready = 1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (out_if.valid !== 1'b1 || out_if.pc !== 8'(i) || out_if.result !== 32'(i * 3 + 1))
        $display("FAIL full_drain%0d got pc=%0h res=%0h want pc=%0h res=%0h", i,
                 out_if.pc, out_if.result, i, i * 3 + 1);
      else n_pass++;
      clk_step();
    end
    out_if.ready = 0;
    n_checks++; if (count !== 5'd0) $display("FAIL full_empty got %0d want 0", count); else n_pass++;
    clear_ovf = 1;
    clk_step();
    clear_ovf = 0;
    n_checks++;
    if (overflow !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL clear_ovf got ovf=%0h drops=%0d want 0 0", overflow, drop_count);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    out_if.ready = 0; trace_en = 1;
    for (int i = 0; i < 16; i++) begin
      pc = 8'(100 + i); result = 32'(i);
      clk_step();
    end
    pc = 8'd200; result = 32'hCAFE; out_if.ready = 1;
    clk_step();
    trace_en = 0;
    n_checks++; if (count !== 5'd16) $display("FAIL pp_count got %0d want 16", count); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL pp_ovf got %0h want 0", overflow); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      logic [PC_W-1:0] want_pc;
      want_pc = (i == 15) ? 8'd200 : 8'(101 + i);
      n_checks++;
      if (out_if.pc !== want_pc) $display("FAIL pp_drain%0d got %0d want %0d", i, out_if.pc, want_pc);
      else n_pass++;
      clk_step();
    end
    out_if.ready = 0;
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0] got[$];
    int max_cnt = 0;
    out_if.ready = 1; trace_en = 1;
    for (int i = 0; i < 40; i++) begin
      if (out_if.valid) got.push_back(out_if.pc);
      pc = 8'(50 + i); result = 32'(i);
      clk_step();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    trace_en = 0;
    for (int i = 0; i < 3; i++) begin
      if (out_if.valid) got.push_back(out_if.pc);
      clk_step();
    end
    out_if.ready = 0;
    n_checks++; if (got.size() != 40) $display("FAIL stream_pops got %0d want 40", got.size()); else n_pass++;
    n_checks++; if (max_cnt > 1) $display("FAIL stream_maxcount got %0d want <=1", max_cnt); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL stream_ovf got %0h want 0", overflow); else n_pass++;
    for (int k = 0; k < got.size() && k < 40; k++) begin
      n_checks++;
      if (got[k] !== 8'(50 + k)) $display("FAIL stream_pc%0d got %0d want %0d", k, got[k], 50 + k);
      else n_pass++;
    end
  endtask

  task automatic test_reenable_reset();
    out_if.ready = 0; pc = 8'd7; result = 32'd77; trace_en = 1;
    clk_step(); clk_step();
    n_checks++; if (count !== 5'd1) $display("FAIL reen_first got %0d want 1", count); else n_pass++;
    trace_en = 0;
    clk_step();
    trace_en = 1;
    clk_step(); clk_step();
    n_checks++; if (count !== 5'd2) $display("FAIL reen_second got %0d want 2", count); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      pc = 8'(i);
      clk_step();
    end
    trace_en = 0;
    n_checks++; if (count !== 5'd5) $display("FAIL reen_five got %0d want 5", count); else n_pass++;
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (count !== 5'd0 || out_if.valid !== 1'b0)
      $display("FAIL async_reset got count=%0d valid=%0h want 0 0", count, out_if.valid);
    else n_pass++;
    clk_step();
    rst_n = 1;
    clk_step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      trace_en     = ($urandom_range(0, 9) != 0);
      pc           = 8'($urandom_range(0, 3));
      result       = $urandom;
      out_if.ready = ($urandom_range(0, 2) == 0);
      clear_ovf    = ($urandom_range(0, 40) == 0);
      clk_step();
      n_checks++;
      if (int'(count) != mq.size() || out_if.valid !== (mq.size() != 0))
        $display("FAIL rand_count c%0d got %0d/%0h want %0d", c, count, out_if.valid, mq.size());
      else n_pass++;
      if (mq.size() != 0) begin
        n_checks++;
        if (out_if.pc !== mq[0].pc || out_if.result !== mq[0].res)
          $display("FAIL rand_head c%0d got %0h/%0h want %0h/%0h", c, out_if.pc, out_if.result,
                   mq[0].pc, mq[0].res);
        else n_pass++;
      end
      n_checks++;
      if (overflow !== m_ovf || int'(drop_count) != m_drops)
        $display("FAIL rand_ovf c%0d got %0h/%0d want %0h/%0d", c, overflow, drop_count, m_ovf, m_drops);
      else n_pass++;
    end
    clear_ovf = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_retire_detect();
    test_full_drop();
    test_full_push_pop();
    test_streaming();
    test_reenable_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
